data_bus_ram_ctrl: RTL and testbench

//  Parametrised data-memory controller between the core load/store unit and on-chip RAM.

---
 rtl/data_bus_ram_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_data_bus_ram_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_bus_ram_ctrl.sv
// Data-memory controller: valid/ready request port in front of a byte-lane RAM
// (primary + alias window) and a small status/counter register window.
module data_bus_ram_ctrl #(
   parameter int unsigned RAM_WORDS   = 1024,
   parameter logic [31:0] RAM_BASE    = 32'h0000_1000,
   parameter logic [31:0] ALIAS_BASE  = 32'h8000_1000,
   parameter logic [31:0] REG_BASE    = 32'hFFFF_FF00,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic        rsp_err,
   output logic [31:0] rsp_rdata,
   output logic        exc_unmapped,
   output logic        exc_misalign
);

   localparam int unsigned IDX_W     = $clog2(RAM_WORDS);
   localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);
   localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_RESP
   } state_t;

   state_t             state_q, state_d;
   logic [3:0]         wait_q, wait_d;

   logic               we_q;
   logic [1:0]         size_q;
   logic               uns_q;
   logic [1:0]         lane_q;
   logic [1:0]         reg_sel_q;
   logic               err_q;
   logic               ram_q;
   logic [IDX_W-1:0]   idx_q;
   logic [3:0]         be_q;
   logic [31:0]        wr_data_q;

   logic               exc_unm_q;
   logic               exc_mis_q;
   logic [31:0]        count_q;

   logic [31:0]        ram_off, alias_off, reg_off;
   logic               hit_ram, hit_alias, hit_reg, dec_ram, dec_reg;
   logic               dec_mis, dec_unm, dec_err;
   logic [IDX_W-1:0]   dec_idx;
   logic [3:0]         dec_be;
   logic [31:0]        dec_wdata;
   logic               accept;
   logic               leave_access;
   logic               resp_act;

   logic [31:0]        rd_word;
   logic [31:0]        shifted;
   logic [31:0]        ram_fmt;
   logic [31:0]        reg_rdata;

   // Window hits use wrap-free unsigned offsets so each window is one compare.
   assign ram_off   = req_addr - RAM_BASE;
   assign alias_off = req_addr - ALIAS_BASE;
   assign reg_off   = req_addr - REG_BASE;
   assign hit_ram   = ram_off < RAM_BYTES;
   assign hit_alias = alias_off < RAM_BYTES;
   assign hit_reg   = reg_off < 32'd16;
   assign dec_ram   = hit_ram | hit_alias;
   assign dec_reg   = hit_reg & ~dec_ram;
   assign dec_idx   = hit_ram ? ram_off[IDX_W+1:2] : alias_off[IDX_W+1:2];

   always_comb begin
      dec_mis   = 1'b0;
      dec_be    = 4'b1111;
      dec_wdata = req_wdata;
      unique case (req_size)
         2'b00: begin
            dec_be    = 4'b0001 << req_addr[1:0];
            dec_wdata = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            dec_mis   = req_addr[0];
            dec_be    = req_addr[1] ? 4'b1100 : 4'b0011;
            dec_wdata = {2{req_wdata[15:0]}};
         end
         2'b10: dec_mis = |req_addr[1:0];
         default: dec_mis = 1'b1;
      endcase
      if (dec_reg && req_size != 2'b10) begin
         dec_mis = 1'b1;
      end
   end

   assign dec_unm      = ~(dec_ram | dec_reg);
   assign dec_err      = dec_mis | dec_unm;
   assign req_ready    = (state_q == ST_IDLE) && !rst;
   assign accept       = req_valid && req_ready;
   assign leave_access = (state_q == ST_ACCESS) && (wait_q == 4'd0);

   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (!dec_err && dec_ram) begin
                  state_d = ST_ACCESS;
                  wait_d  = WAIT_INIT;
               end else begin
                  state_d = ST_RESP;
               end
            end
         end
         ST_ACCESS: begin
            if (wait_q == 4'd0) begin
               state_d = ST_RESP;
            end else begin
               wait_d = wait_q - 4'd1;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Sticky status and W1C clear both act on the accept edge, so they are
   // already visible when the response strobe appears.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         wait_q    <= 4'd0;
         exc_unm_q <= 1'b0;
         exc_mis_q <= 1'b0;
         count_q   <= 32'd0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         if (accept) begin
            if (dec_mis) begin
               exc_mis_q <= 1'b1;
            end else if (dec_unm) begin
               exc_unm_q <= 1'b1;
            end else if (dec_reg && req_we && reg_off[3:2] == 2'd0) begin
               exc_unm_q <= exc_unm_q & ~req_wdata[0];
               exc_mis_q <= exc_mis_q & ~req_wdata[1];
            end
         end
         if (leave_access) begin
            count_q <= count_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         we_q      <= req_we;
         size_q    <= req_size;
         uns_q     <= req_unsigned;
         lane_q    <= req_addr[1:0];
         reg_sel_q <= reg_off[3:2];
         err_q     <= dec_err;
         ram_q     <= dec_ram;
         idx_q     <= dec_idx;
         be_q      <= dec_be;
         wr_data_q <= dec_wdata;
      end
   end

   // One byte-wide RAM per lane; the write is gated by rst so a reset on the
   // commit edge drops the store.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] mem [RAM_WORDS];
         logic [7:0] rd_byte_q;

         always_ff @(posedge clk) begin
            if (leave_access) begin
               if (!rst && we_q && be_q[gi]) begin
                  mem[idx_q] <= wr_data_q[8*gi +: 8];
               end
               rd_byte_q <= mem[idx_q];
            end
         end

         assign rd_word[8*gi +: 8] = rd_byte_q;
      end
   endgenerate

   always_comb begin
      shifted = rd_word >> {lane_q, 3'b000};
      ram_fmt = rd_word;
      unique case (size_q)
         2'b00:   ram_fmt = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
         2'b01:   ram_fmt = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
         default: ram_fmt = rd_word;
      endcase
   end

   always_comb begin
      reg_rdata = 32'd0;
      unique case (reg_sel_q)
         2'd0:    reg_rdata = {30'd0, exc_mis_q, exc_unm_q};
         2'd1:    reg_rdata = count_q;
         default: reg_rdata = 32'd0;
      endcase
   end

   assign resp_act     = (state_q == ST_RESP) && !rst;
   assign rsp_valid    = resp_act;
   assign rsp_err      = resp_act & err_q;
   assign rsp_rdata    = (resp_act && !err_q && !we_q) ? (ram_q ? ram_fmt : reg_rdata) : 32'd0;
   assign exc_unmapped = exc_unm_q & ~rst;
   assign exc_misalign = exc_mis_q & ~rst;

endmodule

// File: tb/tb_data_bus_ram_ctrl.sv
// Bench for data_bus_ram_ctrl: two instances (0 and 3 wait states), directed
// vector table, reset corner cases and random traffic against a reference model.
module tb_data_bus_ram_ctrl;

   localparam logic [31:0] RB = 32'h0000_1000;
   localparam logic [31:0] AB = 32'h8000_1000;
   localparam logic [31:0] GB = 32'hFFFF_FF00;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]       rst, req_valid, req_ready, req_we, req_unsigned;
   logic [1:0]       rsp_valid, rsp_err, exc_unmapped, exc_misalign;
   logic [1:0][1:0]  req_size;
   logic [1:0][31:0] req_addr, req_wdata, rsp_rdata;

   int total = 0;
   int bad   = 0;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_dut
         data_bus_ram_ctrl #(
            .RAM_WORDS   (1024),
            .RAM_BASE    (RB),
            .ALIAS_BASE  (AB),
            .REG_BASE    (GB),
            .WAIT_STATES (gi * 3)
         ) u_dut (
            .clk          (clk),
            .rst          (rst[gi]),
            .req_valid    (req_valid[gi]),
            .req_ready    (req_ready[gi]),
            .req_we       (req_we[gi]),
            .req_size     (req_size[gi]),
            .req_unsigned (req_unsigned[gi]),
            .req_addr     (req_addr[gi]),
            .req_wdata    (req_wdata[gi]),
            .rsp_valid    (rsp_valid[gi]),
            .rsp_err      (rsp_err[gi]),
            .rsp_rdata    (rsp_rdata[gi]),
            .exc_unmapped (exc_unmapped[gi]),
            .exc_misalign (exc_misalign[gi])
         );
      end
   endgenerate

   // Reference model state: word-addressed RAM image, sticky bits, counter.
   bit [31:0] mm [2][1024];
   bit        mexc_u [2];
   bit        mexc_m [2];
   bit [31:0] mcount [2];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic model_req(input int d, input bit we, input bit [1:0] sz, input bit uns,
                            input bit [31:0] addr, input bit [31:0] wd,
                            output bit err, output bit [31:0] rd, output bit ram);
      longint a = longint'(addr);
      int     idx = 0;
      int     nb;
      int     lane;
      bit     regh = 1'b0;
      bit     mis;
      bit [31:0] w;
      bit [31:0] mask;
      ram = 1'b0;
      rd  = 32'd0;
      if (a >= longint'(RB) && a < longint'(RB) + 4096) begin
         ram = 1'b1; idx = int'((a - longint'(RB)) / 4);
      end else if (a >= longint'(AB) && a < longint'(AB) + 4096) begin
         ram = 1'b1; idx = int'((a - longint'(AB)) / 4);
      end else if (a >= longint'(GB) && a < longint'(GB) + 16) begin
         regh = 1'b1;
      end
      nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      mis = (sz == 2'd3) || (a % nb != 0) || (regh && sz != 2'd2);
      err = mis || (!ram && !regh);
      if (err) begin
         if (mis) mexc_m[d] = 1'b1;
         else     mexc_u[d] = 1'b1;
         ram = 1'b0;
         return;
      end
      lane = int'(a % 4);
      if (ram) begin
         mcount[d]++;
         w = mm[d][idx];
         if (we) begin
            for (int k = 0; k < nb; k++) w[8*(lane+k) +: 8] = wd[8*k +: 8];
            mm[d][idx] = w;
         end else begin
            mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*nb)) - 32'd1);
            w = (w >> (8*lane)) & mask;
            if (!uns && nb < 4 && w[8*nb-1]) w = w | ~mask;
            rd = w;
         end
      end else begin
         if (we) begin
            if (a == longint'(GB)) begin
               if (wd[0]) mexc_u[d] = 1'b0;
               if (wd[1]) mexc_m[d] = 1'b0;
            end
         end else begin
            if (a == longint'(GB))          rd = {30'd0, mexc_m[d], mexc_u[d]};
            else if (a == longint'(GB) + 4) rd = mcount[d];
         end
      end
   endtask

   // Called at a negedge with the instance idle; returns at a negedge.
   task automatic xact(input int d, input bit we, input bit [1:0] sz, input bit uns,
                       input bit [31:0] addr, input bit [31:0] wd,
                       output logic [31:0] rd_o, output logic err_o);
      bit        e_err, e_ram, got;
      bit [31:0] e_rd;
      int        lat, exp_lat;
      check("ready_before", req_ready[d], 1);
      req_valid[d] = 1'b1; req_we[d] = we; req_size[d] = sz;
      req_unsigned[d] = uns; req_addr[d] = addr; req_wdata[d] = wd;
      model_req(d, we, sz, uns, addr, wd, e_err, e_rd, e_ram);
      exp_lat = e_ram ? (d * 3 + 2) : 1;
      @(posedge clk);
      #1;
      req_valid[d] = 1'b0; req_addr[d] = $urandom; req_wdata[d] = $urandom;
      req_size[d] = 2'($urandom); req_we[d] = 1'($urandom); req_unsigned[d] = 1'($urandom);
      got = 1'b0; lat = 0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (rsp_valid[d]) begin
            lat = c; got = 1'b1;
            break;
         end
         check("busy_ready", req_ready[d], 0);
      end
      rd_o = 32'd0; err_o = 1'b0;
      if (!got) begin
         total++; bad++;
         $display("FAIL rsp_timeout: d=%0d addr=%08h got no rsp_valid expected one", d, addr);
      end else begin
         check("latency", lat, exp_lat);
         check("rsp_err", rsp_err[d], e_err);
         check("rsp_rdata", rsp_rdata[d], e_rd);
         check("exc_unmapped", exc_unmapped[d], mexc_u[d]);
         check("exc_misalign", exc_misalign[d], mexc_m[d]);
         check("resp_ready", req_ready[d], 0);
         rd_o = rsp_rdata[d]; err_o = rsp_err[d];
      end
      $display("xact d=%0d we=%0d sz=%0d uns=%0d addr=%08h wd=%08h rdata=%08h err=%0d lat=%0d",
               d, we, sz, uns, addr, wd, rd_o, err_o, lat);
      @(negedge clk);
      check("strobe_end", rsp_valid[d], 0);
      check("idle_ready", req_ready[d], 1);
   endtask

   typedef struct {
      bit        we;
      bit [1:0]  sz;
      bit        uns;
      bit [31:0] addr;
      bit [31:0] wd;
      bit        err;
      bit [31:0] rd;
      bit [1:0]  exc;   // {misalign, unmapped}
   } vec_t;

   vec_t tbl [32];

   function automatic bit [31:0] rand_addr();
      bit [31:0] off = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
      case ($urandom_range(0, 4))
         0, 1:    return RB + off;
         2:       return AB + off;
         3:       return GB + 32'($urandom_range(0, 15));
         default: begin
            case ($urandom_range(0, 3))
               0:       return RB - 32'($urandom_range(1, 64));
               1:       return RB + 32'd4096 + 32'($urandom_range(0, 64));
               2:       return AB - 32'($urandom_range(1, 64));
               default: return 32'h4000_0000 + 32'($urandom_range(0, 255));
            endcase
         end
      endcase
   endfunction

   initial begin
      logic [31:0] rd;
      logic        er;

      tbl[0]  = '{1, 2, 0, 32'h0000_1000, 32'hDEAD_BEEF, 0, 32'h0000_0000, 2'b00};
      tbl[1]  = '{0, 2, 0, 32'h0000_1000, 32'h0,         0, 32'hDEAD_BEEF, 2'b00};
      tbl[2]  = '{0, 2, 0, 32'h8000_1000, 32'h0,         0, 32'hDEAD_BEEF, 2'b00};
      tbl[3]  = '{1, 2, 0, 32'h0000_1000, 32'h1122_3344, 0, 32'h0000_0000, 2'b00};
      tbl[4]  = '{1, 0, 0, 32'h0000_1003, 32'h1234_5680, 0, 32'h0000_0000, 2'b00};
      tbl[5]  = '{0, 2, 0, 32'h0000_1000, 32'h0,         0, 32'h8022_3344, 2'b00};
      tbl[6]  = '{0, 0, 0, 32'h0000_1003, 32'h0,         0, 32'hFFFF_FF80, 2'b00};
      tbl[7]  = '{0, 0, 1, 32'h0000_1003, 32'h0,         0, 32'h0000_0080, 2'b00};
      tbl[8]  = '{0, 1, 0, 32'h0000_1002, 32'h0,         0, 32'hFFFF_8022, 2'b00};
      tbl[9]  = '{0, 2, 0, 32'h0000_1002, 32'h0,         1, 32'h0000_0000, 2'b10};
      tbl[10] = '{0, 2, 0, 32'h0000_1000, 32'h0,         0, 32'h8022_3344, 2'b10};
      tbl[11] = '{0, 2, 0, 32'h0000_0100, 32'h0,         1, 32'h0000_0000, 2'b11};
      tbl[12] = '{1, 2, 0, 32'hFFFF_FF00, 32'h0000_0003, 0, 32'h0000_0000, 2'b00};
      tbl[13] = '{0, 2, 0, 32'hFFFF_FF04, 32'h0,         0, 32'h0000_000A, 2'b00};
      tbl[14] = '{0, 1, 0, 32'hFFFF_FF00, 32'h0,         1, 32'h0000_0000, 2'b10};
      tbl[15] = '{0, 2, 0, 32'hFFFF_FF08, 32'h0,         0, 32'h0000_0000, 2'b10};
      tbl[16] = '{1, 2, 0, 32'hFFFF_FF0C, 32'h0000_0001, 0, 32'h0000_0000, 2'b10};
      tbl[17] = '{1, 2, 0, 32'hFFFF_FF00, 32'h0000_0002, 0, 32'h0000_0000, 2'b00};
      tbl[18] = '{0, 3, 0, 32'h0000_1000, 32'h0,         1, 32'h0000_0000, 2'b10};
      tbl[19] = '{0, 1, 1, 32'h0000_1001, 32'h0,         1, 32'h0000_0000, 2'b10};
      tbl[20] = '{0, 2, 0, 32'h0000_2000, 32'h0,         1, 32'h0000_0000, 2'b11};
      tbl[21] = '{1, 2, 0, 32'h0000_1FFC, 32'hCAFE_F00D, 0, 32'h0000_0000, 2'b11};
      tbl[22] = '{0, 0, 1, 32'h8000_1FFF, 32'h0,         0, 32'h0000_00CA, 2'b11};
      tbl[23] = '{0, 1, 0, 32'h8000_1FFE, 32'h0,         0, 32'hFFFF_CAFE, 2'b11};
      tbl[24] = '{1, 1, 0, 32'h8000_1FFC, 32'hFFFF_BEEF, 0, 32'h0000_0000, 2'b11};
      tbl[25] = '{0, 2, 0, 32'h0000_1FFC, 32'h0,         0, 32'hCAFE_BEEF, 2'b11};
      tbl[26] = '{0, 2, 0, 32'hFFFF_FF04, 32'h0,         0, 32'h0000_000F, 2'b11};
      tbl[27] = '{1, 2, 0, 32'hFFFF_FF04, 32'hFFFF_FFFF, 0, 32'h0000_0000, 2'b11};
      tbl[28] = '{0, 2, 0, 32'hFFFF_FF04, 32'h0,         0, 32'h0000_000F, 2'b11};
      tbl[29] = '{1, 2, 0, 32'hFFFF_FF00, 32'hFFFF_FFFF, 0, 32'h0000_0000, 2'b00};
      tbl[30] = '{0, 2, 0, 32'h0000_0102, 32'h0,         1, 32'h0000_0000, 2'b10};
      tbl[31] = '{0, 0, 0, 32'h0000_0FFF, 32'h0,         1, 32'h0000_0000, 2'b11};

      rst = 2'b11; req_valid = '0; req_we = '0; req_unsigned = '0;
      req_size = '0; req_addr = '0; req_wdata = '0;

      // Reset: outputs quiet and not ready while rst is high.
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            check("rst_ready", req_ready[d], 0);
            check("rst_rsp_valid", rsp_valid[d], 0);
            check("rst_rsp_err", rsp_err[d], 0);
            check("rst_rsp_rdata", rsp_rdata[d], 0);
            check("rst_exc", {exc_misalign[d], exc_unmapped[d]}, 0);
         end
      end
      rst = 2'b00;
      @(negedge clk);
      for (int d = 0; d < 2; d++) check("post_rst_ready", req_ready[d], 1);

      // Directed vectors on the zero-wait-state instance.
      for (int i = 0; i < 32; i++) begin
         xact(0, tbl[i].we, tbl[i].sz, tbl[i].uns, tbl[i].addr, tbl[i].wd, rd, er);
         check($sformatf("tbl%0d_rdata", i), rd, tbl[i].rd);
         check($sformatf("tbl%0d_err", i), er, tbl[i].err);
         check($sformatf("tbl%0d_exc", i), {exc_misalign[0], exc_unmapped[0]}, tbl[i].exc);
      end

      // Three wait states: latency 5, COUNT tracks successful RAM accesses.
      xact(1, 1, 2, 0, 32'h0000_1010, 32'h0BAD_F00D, rd, er);
      xact(1, 0, 2, 0, 32'h8000_1010, 32'h0, rd, er);
      check("ws3_load", rd, 32'h0BAD_F00D);
      xact(1, 0, 2, 0, 32'hFFFF_FF04, 32'h0, rd, er);
      check("ws3_count", rd, 32'd2);
      xact(1, 1, 2, 0, 32'h0000_1020, 32'h1234_5678, rd, er);

      // Reset on the commit edge of a store: store dropped, no response.
      req_valid[1] = 1'b1; req_we[1] = 1'b1; req_size[1] = 2'd2;
      req_unsigned[1] = 1'b0; req_addr[1] = 32'h0000_1020; req_wdata[1] = 32'hFFFF_FFFF;
      check("abort_ready", req_ready[1], 1);
      @(posedge clk);
      #1;
      req_valid[1] = 1'b0;
      repeat (4) @(negedge clk);
      check("abort_busy", req_ready[1], 0);
      rst[1] = 1'b1;
      @(negedge clk);
      check("abort_rst_ready", req_ready[1], 0);
      check("abort_rst_valid", rsp_valid[1], 0);
      rst[1] = 1'b0;
      mexc_u[1] = 1'b0; mexc_m[1] = 1'b0; mcount[1] = 32'd0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check("abort_no_rsp", rsp_valid[1], 0);
         check("abort_idle", req_ready[1], 1);
      end
      xact(1, 0, 2, 0, 32'h0000_1020, 32'h0, rd, er);
      check("abort_kept", rd, 32'h1234_5678);
      xact(1, 0, 2, 0, 32'hFFFF_FF04, 32'h0, rd, er);
      check("abort_count", rd, 32'd1);

      // Random traffic on both instances after seeding the address region.
      for (int d = 0; d < 2; d++) begin
         for (int w = 0; w < 16; w++) begin
            xact(d, 1, 2, 0, RB + 32'(w * 4), $urandom, rd, er);
         end
         for (int n = 0; n < 150; n++) begin
            xact(d, 1'($urandom), 2'($urandom), 1'($urandom), rand_addr(), $urandom, rd, er);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
